// File: rtl/sh2_mem_arbiter.sv
// sh2_mem_arbiter
// Shares one synchronous work-RAM port between two SH-2-style bus masters.
// A master raises REQ and holds it until a one-CE-period RDY pulse; the
// arbiter grants one master, drives the RAM for 1+WAIT_CYCLES CE strobes,
// returns read data, then spends one strobe in DONE before re-arbitrating.
// All state and outputs advance only on CLK edges with CE_R=1.
//
// Ports:
//   CLK, RST (sync, active high), CE_R (clock enable)
//   Mx_REQ/Mx_A/Mx_DO/Mx_WE_N  master x request, byte address, write data,
//                              active-low byte enables (4'hF = read)
//   Mx_DI/Mx_RDY               read data and one-strobe completion pulse
//   MEM_A/MEM_DI/MEM_WE/MEM_RD RAM address, write data, byte strobes, read enable
//   MEM_DO                     RAM read data, valid while MEM_RD is held
//   GNT                        one-hot current owner, 2'b00 when idle
module sh2_mem_arbiter #(
    parameter int ADDR_W      = 27,
    parameter int WAIT_CYCLES = 2,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic              M0_REQ,
    input  logic [ADDR_W-1:0] M0_A,
    input  logic [31:0]       M0_DO,
    input  logic [3:0]        M0_WE_N,
    output logic [31:0]       M0_DI,
    output logic              M0_RDY,
    input  logic              M1_REQ,
    input  logic [ADDR_W-1:0] M1_A,
    input  logic [31:0]       M1_DO,
    input  logic [3:0]        M1_WE_N,
    output logic [31:0]       M1_DI,
    output logic              M1_RDY,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [31:0]       MEM_DI,
    output logic [3:0]        MEM_WE,
    output logic              MEM_RD,
    input  logic [31:0]       MEM_DO,
    output logic [1:0]        GNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                owner;    // 0 = master 0, 1 = master 1
    logic                rr_last;  // owner of the most recently completed access
    logic                pick;
    logic [ADDR_W-1:0]   sel_a;
    logic [31:0]         sel_do;
    logic [3:0]          sel_we_n;

    // Arbitration: a lone requester wins; on a tie either master 0 (fixed)
    // or whichever master did not own the previous access (round-robin).
    always_comb begin
        pick = 1'b0;
        if (M0_REQ && M1_REQ) begin
            pick = FIXED_PRIO ? 1'b0 : ~rr_last;
        end else if (M1_REQ) begin
            pick = 1'b1;
        end
        sel_a    = pick ? M1_A    : M0_A;
        sel_do   = pick ? M1_DO   : M0_DO;
        sel_we_n = pick ? M1_WE_N : M0_WE_N;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            owner   <= 1'b0;
            rr_last <= 1'b1;
            M0_DI   <= '0;
            M0_RDY  <= 1'b0;
            M1_DI   <= '0;
            M1_RDY  <= 1'b0;
            MEM_A   <= '0;
            MEM_DI  <= '0;
            MEM_WE  <= '0;
            MEM_RD  <= 1'b0;
            GNT     <= '0;
        end else if (CE_R) begin
            case (state)
                ST_IDLE: begin
                    if (M0_REQ || M1_REQ) begin
                        owner  <= pick;
                        GNT    <= pick ? 2'b10 : 2'b01;
                        MEM_A  <= sel_a;
                        MEM_DI <= sel_do;
                        if (sel_we_n != 4'hF) begin
                            MEM_WE <= ~sel_we_n;
                            MEM_RD <= 1'b0;
                        end else begin
                            MEM_WE <= '0;
                            MEM_RD <= 1'b1;
                        end
                        cnt   <= 4'(WAIT_CYCLES);
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Write strobe lasts exactly the first ACCESS period.
                    MEM_WE <= '0;
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // MEM_RD still marks a read here; it drops on this edge.
                        if (owner) begin
                            if (MEM_RD) M1_DI <= MEM_DO;
                            M1_RDY <= M1_REQ;
                        end else begin
                            if (MEM_RD) M0_DI <= MEM_DO;
                            M0_RDY <= M0_REQ;
                        end
                        MEM_RD  <= 1'b0;
                        rr_last <= owner;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    M0_RDY <= 1'b0;
                    M1_RDY <= 1'b0;
                    GNT    <= '0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sh2_mem_arbiter.sv
// Bench for sh2_mem_arbiter. Three instances share one stimulus:
//   d0: round-robin, WAIT_CYCLES=2 (directed literal expectations)
//   d1: fixed priority, WAIT_CYCLES=2
//   d2: round-robin, WAIT_CYCLES=0
// A transaction-age model predicts every output of every instance each cycle.
module tb_sh2_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [26:0] m0_a = '0, m1_a = '0;
    logic [31:0] m0_do = '0, m1_do = '0, mem_do = '0;
    logic [3:0]  m0_we_n = 4'hF, m1_we_n = 4'hF;

    logic [2:0][31:0] o_m0_di, o_m1_di, o_mem_di;
    logic [2:0]       o_m0_rdy, o_m1_rdy, o_mem_rd;
    logic [2:0][26:0] o_mem_a;
    logic [2:0][3:0]  o_mem_we;
    logic [2:0][1:0]  o_gnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sh2_mem_arbiter #(
            .ADDR_W     (27),
            .WAIT_CYCLES((g == 2) ? 0 : 2),
            .FIXED_PRIO ((g == 1) ? 1'b1 : 1'b0)
        ) u_dut (
            .CLK    (clk),
            .RST    (rst),
            .CE_R   (ce),
            .M0_REQ (m0_req),
            .M0_A   (m0_a),
            .M0_DO  (m0_do),
            .M0_WE_N(m0_we_n),
            .M0_DI  (o_m0_di[g]),
            .M0_RDY (o_m0_rdy[g]),
            .M1_REQ (m1_req),
            .M1_A   (m1_a),
            .M1_DO  (m1_do),
            .M1_WE_N(m1_we_n),
            .M1_DI  (o_m1_di[g]),
            .M1_RDY (o_m1_rdy[g]),
            .MEM_A  (o_mem_a[g]),
            .MEM_DI (o_mem_di[g]),
            .MEM_WE (o_mem_we[g]),
            .MEM_RD (o_mem_rd[g]),
            .MEM_DO (mem_do),
            .GNT    (o_gnt[g])
        );
    end

    function automatic int wc(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    function automatic bit fp(input int i);
        return (i == 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each access is a transaction whose age counts CE strobes since
    // the grant; outputs follow from the age (complete at 1+W, release at 2+W).
    bit          busy[3], own[3], rrl[3], rdf[3];
    int          age[3];
    logic [3:0]  mwe;
    logic [31:0] e_m0_di[3], e_m1_di[3], e_mem_di[3];
    logic        e_m0_rdy[3], e_m1_rdy[3], e_mem_rd[3];
    logic [26:0] e_mem_a[3];
    logic [3:0]  e_mem_we[3];
    logic [1:0]  e_gnt[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                busy[i] = 1'b0; own[i] = 1'b0; rrl[i] = 1'b1; rdf[i] = 1'b0; age[i] = 0;
                e_m0_di[i] = '0; e_m1_di[i] = '0; e_mem_di[i] = '0;
                e_m0_rdy[i] = 1'b0; e_m1_rdy[i] = 1'b0; e_mem_rd[i] = 1'b0;
                e_mem_a[i] = '0; e_mem_we[i] = '0; e_gnt[i] = '0;
            end else if (ce) begin
                if (!busy[i]) begin
                    if (m0_req || m1_req) begin
                        own[i] = (m0_req && m1_req) ? (fp(i) ? 1'b0 : !rrl[i]) : m1_req;
                        busy[i] = 1'b1;
                        age[i] = 0;
                        e_gnt[i] = own[i] ? 2'b10 : 2'b01;
                        e_mem_a[i] = own[i] ? m1_a : m0_a;
                        e_mem_di[i] = own[i] ? m1_do : m0_do;
                        mwe = own[i] ? m1_we_n : m0_we_n;
                        rdf[i] = (mwe == 4'hF);
                        e_mem_rd[i] = rdf[i];
                        e_mem_we[i] = rdf[i] ? 4'h0 : ~mwe;
                    end
                end else begin
                    age[i]++;
                    e_mem_we[i] = '0;
                    if (age[i] == wc(i) + 1) begin
                        if (own[i]) begin
                            if (rdf[i]) e_m1_di[i] = mem_do;
                            e_m1_rdy[i] = m1_req;
                        end else begin
                            if (rdf[i]) e_m0_di[i] = mem_do;
                            e_m0_rdy[i] = m0_req;
                        end
                        e_mem_rd[i] = 1'b0;
                        rrl[i] = own[i];
                    end else if (age[i] == wc(i) + 2) begin
                        e_m0_rdy[i] = 1'b0;
                        e_m1_rdy[i] = 1'b0;
                        e_gnt[i] = '0;
                        busy[i] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("d%0d.m0_di", i),   o_m0_di[i],         e_m0_di[i]);
                chk($sformatf("d%0d.m0_rdy", i),  32'(o_m0_rdy[i]),   32'(e_m0_rdy[i]));
                chk($sformatf("d%0d.m1_di", i),   o_m1_di[i],         e_m1_di[i]);
                chk($sformatf("d%0d.m1_rdy", i),  32'(o_m1_rdy[i]),   32'(e_m1_rdy[i]));
                chk($sformatf("d%0d.mem_a", i),   32'(o_mem_a[i]),    32'(e_mem_a[i]));
                chk($sformatf("d%0d.mem_di", i),  o_mem_di[i],        e_mem_di[i]);
                chk($sformatf("d%0d.mem_we", i),  32'(o_mem_we[i]),   32'(e_mem_we[i]));
                chk($sformatf("d%0d.mem_rd", i),  32'(o_mem_rd[i]),   32'(e_mem_rd[i]));
                chk($sformatf("d%0d.gnt", i),     32'(o_gnt[i]),      32'(e_gnt[i]));
            end
        end
    end

    // Waits (bounded) for d0's RDY of the given master; returns negedges waited.
    task automatic wait_rdy(input bit which, input string nm, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            got = which ? o_m1_rdy[0] : o_m0_rdy[0];
        end
        chk({nm, ".rdy_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, rdcnt, saw0, r0, r1, ovl, d1r0, d1r1, d1g1;
        bit got, g_prev;
        logic [1:0] gseq[$];

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset.gnt",   32'(o_gnt[0]),   32'd0);
        chk("reset.m0_di", o_m0_di[0],      32'd0);
        chk("reset.mem_rd", 32'(o_mem_rd[0]), 32'd0);

        // Single read by master 0.
        m0_req = 1'b1; m0_a = 27'h100; m0_we_n = 4'hF; mem_do = 32'hDEADBEEF;
        rdcnt = 0; got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (o_mem_rd[0]) rdcnt++;
            if (o_m0_rdy[0]) got = 1'b1;
        end
        chk("t1.rdy_seen", 32'(got), 32'd1);
        chk("t1.rd_strobes", 32'(rdcnt), 32'd3);
        chk("t1.m0_di", o_m0_di[0], 32'hDEADBEEF);
        chk("t1.gnt", 32'(o_gnt[0]), 32'd1);
        m0_req = 1'b0;
        @(negedge clk);
        chk("t1.rdy_single", 32'(o_m0_rdy[0]), 32'd0);
        repeat (4) @(negedge clk);

        // Byte write by master 1; inputs changed after grant must be ignored.
        m1_req = 1'b1; m1_a = 27'h204; m1_do = 32'h11223344; m1_we_n = 4'b1110;
        @(negedge clk);
        chk("t2.gnt", 32'(o_gnt[0]), 32'd2);
        chk("t2.mem_we", 32'(o_mem_we[0]), 32'h1);
        chk("t2.mem_di", o_mem_di[0], 32'h11223344);
        m1_a = 27'h3FC; m1_do = 32'hFFFFFFFF; m1_we_n = 4'h0;
        @(negedge clk);
        chk("t2.mem_we_off", 32'(o_mem_we[0]), 32'h0);
        chk("t2.mem_a_held", 32'(o_mem_a[0]), 32'h204);
        wait_rdy(1'b1, "t2", lat);
        m1_req = 1'b0; m1_we_n = 4'hF;
        @(negedge clk);
        chk("t2.rdy_single", 32'(o_m1_rdy[0]), 32'd0);
        repeat (4) @(negedge clk);

        // Contention: both masters hold REQ for four accesses.
        m0_a = 27'h300; m1_a = 27'h400; mem_do = 32'h5A5A0001;
        m0_req = 1'b1; m1_req = 1'b1;
        r0 = 0; r1 = 0; ovl = 0; d1r0 = 0; d1r1 = 0; d1g1 = 0; g_prev = 1'b0;
        for (int n = 0; n < 40 && !(gseq.size() == 4 && r0 + r1 == 4); n++) begin
            @(negedge clk);
            if (o_gnt[0] != 2'b00 && !g_prev) gseq.push_back(o_gnt[0]);
            g_prev = (o_gnt[0] != 2'b00);
            if (o_gnt[0] == 2'b11) ovl++;
            if (o_m0_rdy[0]) r0++;
            if (o_m1_rdy[0]) r1++;
            if (o_m0_rdy[1]) d1r0++;
            if (o_m1_rdy[1]) d1r1++;
            if (o_gnt[1] == 2'b10) d1g1++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("t3.ngrants", 32'(gseq.size()), 32'd4);
        while (gseq.size() < 4) gseq.push_back(2'b00);
        chk("t3.g0", 32'(gseq[0]), 32'd1);
        chk("t3.g1", 32'(gseq[1]), 32'd2);
        chk("t3.g2", 32'(gseq[2]), 32'd1);
        chk("t3.g3", 32'(gseq[3]), 32'd2);
        chk("t3.m0_rdys", 32'(r0), 32'd2);
        chk("t3.m1_rdys", 32'(r1), 32'd2);
        chk("t3.overlap", 32'(ovl), 32'd0);
        chk("t3.fp_m0_rdys", 32'(d1r0), 32'd4);
        chk("t3.fp_m1_rdys", 32'(d1r1), 32'd0);
        chk("t3.fp_m1_gnt", 32'(d1g1), 32'd0);
        repeat (5) @(negedge clk);

        // Reset in the middle of a write.
        m0_req = 1'b1; m0_a = 27'h500; m0_do = 32'hA5A5A5A5; m0_we_n = 4'h0;
        @(negedge clk);
        chk("t4.gnt", 32'(o_gnt[0]), 32'd1);
        chk("t4.mem_we", 32'(o_mem_we[0]), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        chk("t4.rst_mem_we", 32'(o_mem_we[0]), 32'h0);
        chk("t4.rst_gnt", 32'(o_gnt[0]), 32'd0);
        chk("t4.rst_rdy", 32'(o_m0_rdy[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t4.regrant", 32'(o_gnt[0]), 32'd1);
        wait_rdy(1'b0, "t4", lat);
        m0_req = 1'b0; m0_we_n = 4'hF;
        repeat (4) @(negedge clk);

        // Latency with and without a 5-clock CE_R stall.
        m1_req = 1'b1; m1_a = 27'h800; m1_we_n = 4'hF; mem_do = 32'h13572468;
        wait_rdy(1'b1, "t5a", lat);
        chk("t5a.latency", 32'(lat), 32'd4);
        chk("t5a.m1_di", o_m1_di[0], 32'h13572468);
        m1_req = 1'b0;
        repeat (4) @(negedge clk);
        m1_req = 1'b1; mem_do = 32'h24681357;
        lat = 0; got = 1'b0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == 2) ce = 1'b0;
            if (lat == 5) begin
                chk("t5b.frozen_rd", 32'(o_mem_rd[0]), 32'd1);
                chk("t5b.frozen_gnt", 32'(o_gnt[0]), 32'd2);
            end
            if (lat == 7) ce = 1'b1;
            got = o_m1_rdy[0];
        end
        chk("t5b.rdy_seen", 32'(got), 32'd1);
        chk("t5b.latency", 32'(lat), 32'd9);
        m1_req = 1'b0;
        repeat (4) @(negedge clk);

        // Master 0 drops its read request mid-access; master 1 is served next.
        m0_req = 1'b1; m0_a = 27'h600; m0_we_n = 4'hF; mem_do = 32'hCAFEF00D;
        @(negedge clk);
        chk("t6.gnt", 32'(o_gnt[0]), 32'd1);
        m0_req = 1'b0; m1_req = 1'b1; m1_a = 27'h700;
        saw0 = 0; got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (o_m0_rdy[0]) saw0++;
            if (o_gnt[0] == 2'b10) got = 1'b1;
        end
        chk("t6.m1_granted", 32'(got), 32'd1);
        chk("t6.no_m0_rdy", 32'(saw0), 32'd0);
        chk("t6.m0_di", o_m0_di[0], 32'hCAFEF00D);
        wait_rdy(1'b1, "t6", lat);
        m1_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
